tag_alloc32: RTL
================

// Module: tag_alloc32
// PURPOSE
// - 32-entry tag allocator: the encode direction of the 5->32 one-hot decoder.
// - Holds a registered free bitmap and priority-encodes the lowest free entry to a 5-bit tag.
// - Hands tags out under a valid/ready handshake and takes returned tags back.
// - Sits between rename and commit; returned tags are decoded one-hot to clear map bits.
// PARAMETERS
// - RESERVED_MASK  32'h0000_0001  entries never allocated or freed (bit0 = tag 0, x0 style)
// PORTS
// - clk          in   1   core clock; all state on rising edge
// - rst_aL       in   1   asynchronous, active-low reset
// - flush        in   1   sync restore of map/count to reset contents
// - alloc_ready  in   1   consumer takes alloc_tag this cycle
// - alloc_valid  out  1   at least one allocatable entry free
// - alloc_tag    out  5   lowest-index free entry; 5'd0 when !alloc_valid
// - free_valid   in   1   return free_tag this cycle
// - free_tag     in   5   tag being returned
// - free_cnt     out  6   number of free entries (registered)
// - err          out  1   sticky: illegal free seen
// BEHAVIOUR
// Reset (async, rst_aL=0)
// - map = ~RESERVED_MASK; free_cnt = popcount(~RESERVED_MASK) (31 at default); err = 0.
// Outputs
// - alloc_valid = |map; alloc_tag = penc(map).
// - Both are combinational from the map flops only, never from inputs.
// - Tag is visible the same cycle it is offered.
// Allocate
// - alloc_valid & alloc_ready clears map[alloc_tag] at the next edge.
// - alloc_ready while !alloc_valid: no effect.
// Free
// - free_valid with map[free_tag]=0 and RESERVED_MASK[free_tag]=0 sets the bit at the next edge.
// - Free of an already-free or reserved tag: map unchanged, err<=1.
// - Legality is checked against current map, before this cycle's alloc.
// Count
// - free_cnt +1 on accepted free, -1 on accepted alloc, unchanged when both occur.
// - Never wraps: 0 <= free_cnt <= popcount(~RESERVED_MASK).
// Simultaneous alloc and free
// - Both apply (different tags guaranteed by legality).
// - A freed tag is allocatable from the next cycle, never the same cycle (no bypass).
// Flush
// - Synchronous; wins over alloc/free in the same cycle; map and free_cnt take reset values.
// - err is not cleared; only rst_aL clears it.
// Empty
// - map=0 -> alloc_valid=0, alloc_tag=0, free_cnt=0.
// - A free in that cycle makes alloc_valid=1 next cycle.
// Reset mid-operation
// - Async clear; in-flight handshakes are lost; outputs at reset values immediately.
// STRUCTURE
// - Shared package/defines: TAG_W=5, NUM_TAGS=32, default RESERVED_MASK.
// - Sub-module penc32: combinational 32->5 priority encoder, lowest index wins.
//   - Built as four 8-entry groups plus group select; outputs tag and any.
// - Top level:
//   - 32 reset-to-value DFFs for the map; 6-bit count register; err flop.
//   - Reuses the 5->32 decoder twice: alloc_tag one-hot for clear, free_tag one-hot for set.
// TESTING
// - Reset: after rst_aL release -> alloc_valid=1, alloc_tag=1, free_cnt=31, err=0.
// - Drain: alloc_ready=1 for 31 cycles -> tags 1..31 in order.
//   - Then alloc_valid=0, alloc_tag=0, free_cnt=0.
// - Empty + free: free tag 7 on the empty map -> next cycle alloc_valid=1, alloc_tag=7, free_cnt=1.
// - Simultaneous: map has tags 3,9 free; alloc (tag 3) + free 12 same cycle.
//   - Next cycle alloc_tag=9, free_cnt=2.
// - Illegal free: free 0 (reserved) or a free tag -> map/free_cnt unchanged, err=1.
//   - err stays 1 through flush.
// - Flush/reset mid-op: flush with alloc+free asserted -> reset contents next cycle.
//   - rst_aL low mid-cycle -> outputs reset asynchronously.

Source files
------------

// File: rtl/tag_alloc32_pkg.sv
// Shared sizes and helpers for the 32-entry tag allocator.
package tag_alloc32_pkg;
  localparam int TAG_W    = 5;
  localparam int NUM_TAGS = 32;
  localparam int CNT_W    = 6;

  // Tag 0 is hardwired-style (x0) and never handed out.
  localparam logic [NUM_TAGS-1:0] DEFAULT_RESERVED_MASK = 32'h0000_0001;

  function automatic logic [CNT_W-1:0] popcount32(input logic [NUM_TAGS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_TAGS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  function automatic logic [NUM_TAGS-1:0] dec_onehot(input logic [TAG_W-1:0] tag);
    return NUM_TAGS'(1) << tag;
  endfunction
endpackage

// File: rtl/tag_alloc32_penc32.sv
// Combinational 32->5 priority encoder, lowest set index wins.
module penc32
  import tag_alloc32_pkg::*;
(
  input  logic [NUM_TAGS-1:0] req,
  output logic [TAG_W-1:0]    tag,
  output logic                any
);
  logic [3:0] grp_any;
  logic [2:0] grp_idx [4];

  // Four 8-entry groups resolve locally, then the lowest non-empty group is picked.
  always_comb begin
    for (int g = 0; g < 4; g++) begin
      grp_any[g] = |req[g*8 +: 8];
      grp_idx[g] = '0;
      for (int i = 7; i >= 0; i--) begin
        if (req[g*8 + i]) grp_idx[g] = 3'(i);
      end
    end
  end

  always_comb begin
    tag = '0;
    for (int g = 3; g >= 0; g--) begin
      if (grp_any[g]) tag = {2'(g), grp_idx[g]};
    end
  end

  assign any = |grp_any;
endmodule

// File: rtl/tag_alloc32.sv
// 32-entry tag allocator: registered free map, lowest-free tag offered under valid/ready.
module tag_alloc32
  import tag_alloc32_pkg::*;
#(
  parameter logic [NUM_TAGS-1:0] RESERVED_MASK = DEFAULT_RESERVED_MASK
) (
  input  logic             clk,
  input  logic             rst_aL,
  input  logic             flush,
  input  logic             alloc_ready,
  output logic             alloc_valid,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             free_valid,
  input  logic [TAG_W-1:0] free_tag,
  output logic [CNT_W-1:0] free_cnt,
  output logic             err
);
  localparam logic [NUM_TAGS-1:0] MAP_RST = ~RESERVED_MASK;
  localparam logic [CNT_W-1:0]    CNT_RST = popcount32(~RESERVED_MASK);

  logic [NUM_TAGS-1:0] map_q;
  logic [NUM_TAGS-1:0] map_nxt;
  logic [NUM_TAGS-1:0] clr_vec;
  logic [NUM_TAGS-1:0] set_vec;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                err_q;
  logic                alloc_fire;
  logic                free_ok;
  logic                free_bad;

  // Outputs depend only on the map flops, so a freed tag is never offered in its own cycle.
  penc32 u_penc (
    .req (map_q),
    .tag (alloc_tag),
    .any (alloc_valid)
  );

  assign alloc_fire = alloc_valid & alloc_ready;
  assign free_ok    = free_valid & ~map_q[free_tag] & ~RESERVED_MASK[free_tag];
  assign free_bad   = free_valid & ~free_ok;

  assign clr_vec = alloc_fire ? dec_onehot(alloc_tag) : '0;
  assign set_vec = free_ok    ? dec_onehot(free_tag)  : '0;
  assign map_nxt = (map_q & ~clr_vec) | set_vec;

  always_comb begin
    cnt_nxt = cnt_q;
    case ({alloc_fire, free_ok})
      2'b10:   cnt_nxt = cnt_q - CNT_W'(1);
      2'b01:   cnt_nxt = cnt_q + CNT_W'(1);
      default: cnt_nxt = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      map_q <= MAP_RST;
      cnt_q <= CNT_RST;
    end else if (flush) begin
      map_q <= MAP_RST;
      cnt_q <= CNT_RST;
    end else begin
      map_q <= map_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  // err survives flush; only the async reset clears it.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) err_q <= 1'b0;
    else if (free_bad && !flush) err_q <= 1'b1;
  end

  assign free_cnt = cnt_q;
  assign err      = err_q;
endmodule
